// File: rtl/zstr_src_fifo.sv
// ---------------------------------------------------------------------------
// zstr_src_fifo
//
// Purpose:
//   Small source FIFO that turns a load interface (l_vld/l_ack/l_bus) into a
//   valid/acknowledge stream (z_vld/z_ack/z_bus). It keeps a running count of
//   completed stream transfers. An optional pseudo-random throttle can delay
//   the launch of new stream words.
//
// Build option:
//   ZSTR_SRC_THROTTLE_EN - when defined, a 16-bit Galois LFSR (taps
//                          16,14,13,11) advances every cycle and a new word
//                          may only be launched when LFSR[7:0] >= thr. When
//                          undefined, the LFSR is omitted and thr is ignored.
//
// Ports:
//   z_clk    in   1      system clock, rising edge
//   z_rst_n  in   1      asynchronous reset, active-low
//   l_vld    in   1      load valid
//   l_bus    in   BW     load data
//   l_ack    out  1      load acknowledge (FIFO not full)
//   z_vld    out  1      stream valid
//   z_bus    out  BW     stream data (FIFO head, or {BW{XZ}} when idle)
//   z_ack    in   1      stream acknowledge
//   thr      in   8      throttle threshold
//   clr      in   1      synchronous transfer counter clear
//   lvl      out  AW+1   FIFO occupancy
//   cnt      out  CW     completed stream transfers (wraps)
// ---------------------------------------------------------------------------
module zstr_src_fifo #(
    parameter int   BW    = 8,
    parameter int   DEPTH = 4,
    parameter int   AW    = 2,
    parameter int   CW    = 16,
    parameter logic XZ    = 1'b0
) (
    input  logic            z_clk,
    input  logic            z_rst_n,
    input  logic            l_vld,
    input  logic [BW-1:0]   l_bus,
    output logic            l_ack,
    output logic            z_vld,
    output logic [BW-1:0]   z_bus,
    input  logic            z_ack,
    input  logic [7:0]      thr,
    input  logic            clr,
    output logic [AW:0]     lvl,
    output logic [CW-1:0]   cnt
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [BW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_lvl;
    logic          r_vld;
    logic [CW-1:0] r_cnt;

    logic [AW:0]   w_lvl_nxt;
    logic          w_vld_nxt;
    logic          w_load;
    logic          w_pop;
    logic          w_gate;

    // l_ack depends on registered occupancy only, so there is no
    // combinational path from z_ack to l_ack.
    assign l_ack  = (r_lvl != FULL_LVL);
    assign w_load = l_vld & l_ack;
    assign w_pop  = r_vld & z_ack;

`ifdef ZSTR_SRC_THROTTLE_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;

    // Right-shifting Galois form; mask 16'hB400 encodes taps 16,14,13,11.
    assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    always_ff @(posedge z_clk or negedge z_rst_n) begin
        if (!z_rst_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    // thr = 0 always opens the gate since any byte is >= 0.
    assign w_gate = (r_lfsr[7:0] >= thr);
`else
    logic w_unused_thr;
    assign w_unused_thr = ^thr;
    assign w_gate       = 1'b1;
`endif

    always_comb begin
        w_lvl_nxt = r_lvl;
        case ({w_load, w_pop})
            2'b10:   w_lvl_nxt = r_lvl + (AW+1)'(1);
            2'b01:   w_lvl_nxt = r_lvl - (AW+1)'(1);
            default: w_lvl_nxt = r_lvl;
        endcase
    end

    // A word already on the bus and not yet taken stays valid regardless of
    // the gate; the gate only decides whether a new head is launched.
    assign w_vld_nxt = (w_lvl_nxt != '0) && ((r_vld && !w_pop) || w_gate);

    always_ff @(posedge z_clk or negedge z_rst_n) begin
        if (!z_rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_lvl <= '0;
            r_vld <= 1'b0;
        end else begin
            if (w_load) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            r_lvl <= w_lvl_nxt;
            r_vld <= w_vld_nxt;
        end
    end

    // Clear wins over a simultaneous transfer.
    always_ff @(posedge z_clk or negedge z_rst_n) begin
        if (!z_rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Storage is data only; reset just empties the FIFO via the pointers.
    always_ff @(posedge z_clk) begin
        if (w_load) begin
            r_mem[r_wp] <= l_bus;
        end
    end

    assign z_vld = r_vld;
    assign z_bus = r_vld ? r_mem[r_rp] : {BW{XZ}};
    assign lvl   = r_lvl;
    assign cnt   = r_cnt;

endmodule

// File: tb/tb_zstr_src_fifo.sv
module tb_zstr_src_fifo;

    localparam int DEPTH = 4;

    logic       z_clk;
    logic       z_rst_n;
    logic       l_vld;
    logic [7:0] l_bus;
    logic       l_ack;
    logic       z_vld;
    logic [7:0] z_bus;
    logic       z_ack;
    logic [7:0] thr;
    logic       clr;
    logic [2:0] lvl;
    logic [3:0] cnt;

    zstr_src_fifo #(
        .BW(8), .DEPTH(DEPTH), .AW(2), .CW(4), .XZ(1'b0)
    ) dut (
        .z_clk(z_clk), .z_rst_n(z_rst_n),
        .l_vld(l_vld), .l_bus(l_bus), .l_ack(l_ack),
        .z_vld(z_vld), .z_bus(z_bus), .z_ack(z_ack),
        .thr(thr), .clr(clr), .lvl(lvl), .cnt(cnt)
    );

    initial z_clk = 1'b0;
    always #5 z_clk = ~z_clk;

    int n_pass = 0;
    int n_tot  = 0;
    int n_xfer = 0;

    // Behavioural reference: a queue of words plus valid flag and counter.
    logic [7:0]  mq[$];
    bit          mvld;
    int          mcnt;
    logic [15:0] mlfsr;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        mvld  = 1'b0;
        mcnt  = 0;
        mlfsr = 16'hACE1;
    endtask

    // Advance the model for the coming edge, take the edge, compare.
    task automatic tick();
        bit ld, pp, gate;
        logic [7:0] eb;
        if (z_vld === 1'b1 && z_ack === 1'b1) n_xfer++;
        if (!z_rst_n) begin
            model_reset();
        end else begin
            gate = 1'b1;
`ifdef ZSTR_SRC_THROTTLE_EN
            gate  = (mlfsr[7:0] >= thr);
            mlfsr = (mlfsr >> 1) ^ (mlfsr[0] ? 16'hB400 : 16'h0000);
`endif
            ld = l_vld && (mq.size() != DEPTH);
            pp = mvld && z_ack;
            if (clr) mcnt = 0;
            else if (pp) mcnt = (mcnt + 1) % 16;
            if (pp) void'(mq.pop_front());
            if (ld) mq.push_back(l_bus);
            mvld = (mq.size() != 0) && ((mvld && !pp) || gate);
        end
        @(posedge z_clk);
        #1;
        eb = mvld ? mq[0] : 8'h00;
        check("m_vld", z_vld, mvld);
        check("m_bus", z_bus, eb);
        check("m_lvl", lvl, mq.size());
        check("m_lack", l_ack, mq.size() != DEPTH);
        check("m_cnt", cnt, mcnt);
    endtask

    task automatic do_reset();
        z_rst_n = 1'b0;
        tick();
        tick();
        z_rst_n = 1'b1;
    endtask

    typedef struct {
        logic       l_vld;
        logic [7:0] l_bus;
        logic       z_ack;
        logic       e_vld;
        logic [7:0] e_bus;
        logic [2:0] e_lvl;
        logic       e_lack;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        z_rst_n = 1'b0; l_vld = 1'b1; l_bus = 8'h5A; z_ack = 1'b0;
        thr = 8'h00; clr = 1'b0;
        model_reset();

        // Reset held with load valid asserted
        tick(); tick(); tick();
        check("rst_vld", z_vld, 1'b0);
        check("rst_lvl", lvl, 3'd0);
        check("rst_cnt", cnt, 4'd0);
        check("rst_lack", l_ack, 1'b1);
        check("rst_bus", z_bus, 8'h00);
        z_rst_n = 1'b1; l_vld = 1'b0;

        // Streaming table: back-to-back 11..18 with z_ack held high
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 8'h11 + 8'(i), 1'b1, 1'b1, 8'h11 + 8'(i), 3'd1, 1'b1, 4'(i)};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 4'd8};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 4'd8};
        thr = 8'h00;
        for (int i = 0; i < 10; i++) begin
            l_vld = tbl[i].l_vld; l_bus = tbl[i].l_bus; z_ack = tbl[i].z_ack;
            tick();
            check($sformatf("tbl%0d_vld", i), z_vld, tbl[i].e_vld);
            check($sformatf("tbl%0d_bus", i), z_bus, tbl[i].e_bus);
            check($sformatf("tbl%0d_lvl", i), lvl, tbl[i].e_lvl);
            check($sformatf("tbl%0d_lack", i), l_ack, tbl[i].e_lack);
            check($sformatf("tbl%0d_cnt", i), cnt, tbl[i].e_cnt);
        end

        // Full FIFO: 4 loads fill it, 5th waits for a pop
        do_reset();
        thr = 8'h00; z_ack = 1'b0; l_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            l_bus = 8'hA0 + 8'(i);
            tick();
        end
        check("full_lack", l_ack, 1'b0);
        check("full_lvl", lvl, 3'd4);
        l_bus = 8'hA4;
        tick();
        check("full_hold_lvl", lvl, 3'd4);
        check("full_hold_head", z_bus, 8'hA0);
        z_ack = 1'b1;
        tick();
        z_ack = 1'b0;
        check("pulse_lvl", lvl, 3'd3);
        check("pulse_lack", l_ack, 1'b1);
        tick();
        check("fifth_lvl", lvl, 3'd4);
        check("fifth_lack", l_ack, 1'b0);
        l_vld = 1'b0; z_ack = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain%0d", i), z_bus, 8'hA0 + 8'(i));
            tick();
        end
        check("drain_empty", lvl, 3'd0);

        // Stability under heavy throttle
        do_reset();
        thr = 8'hFF; z_ack = 1'b0; l_vld = 1'b1; l_bus = 8'hA5;
        tick();
        l_vld = 1'b0;
        for (int k = 0; k < 3000 && z_vld !== 1'b1; k++) tick();
        check("stab_launch", z_vld, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("stab_vld", z_vld, 1'b1);
            check("stab_bus", z_bus, 8'hA5);
        end
        z_ack = 1'b1;
        tick();
        z_ack = 1'b0;
        check("stab_cnt", cnt, 4'd1);
        check("stab_done", z_vld, 1'b0);

        // Counter wrap and clear priority (CW=4)
        do_reset();
        thr = 8'h00; z_ack = 1'b1; l_vld = 1'b1;
        for (int e = 0; e <= 17; e++) begin
            l_bus = 8'(e);
            clr = (e == 17);
            tick();
            if (e == 15) check("cnt15", cnt, 4'd15);
            if (e == 16) check("cnt_wrap", cnt, 4'd0);
            if (e == 17) check("cnt_clr", cnt, 4'd0);
        end
        clr = 1'b0;

        // Asynchronous reset in the middle of traffic
        z_ack = 1'b0;
        tick(); tick();
        #3;
        z_rst_n = 1'b0;
        #1;
        check("arst_vld", z_vld, 1'b0);
        check("arst_lvl", lvl, 3'd0);
        check("arst_cnt", cnt, 4'd0);
        check("arst_lack", l_ack, 1'b1);
        check("arst_bus", z_bus, 8'h00);
        model_reset();
        tick();
        z_rst_n = 1'b1; l_vld = 1'b1; l_bus = 8'h3C; thr = 8'h00;
        tick();
        check("arst_first", z_bus, 8'h3C);
        l_vld = 1'b0; z_ack = 1'b1;
        tick();

        // Throttle rate over 1000 cycles with the FIFO kept non-empty
        do_reset();
        thr = 8'h80; z_ack = 1'b1; l_vld = 1'b1; l_bus = 8'h77;
        tick();
        n_xfer = 0;
        for (int k = 0; k < 1000; k++) begin
            l_bus = 8'($urandom);
            tick();
        end
`ifdef ZSTR_SRC_THROTTLE_EN
        check("thr_rate_lo", (n_xfer >= 400), 1'b1);
        check("thr_rate_hi", (n_xfer <= 600), 1'b1);
`else
        check("thr_rate", n_xfer, 1000);
`endif

        // Randomised traffic against the reference model
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            l_vld = ($urandom_range(0, 3) != 0);
            l_bus = 8'($urandom);
            z_ack = $urandom_range(0, 1);
            clr   = ($urandom_range(0, 31) == 0);
            thr   = (k < 1000) ? 8'h00 : 8'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
